pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
//  hazards and not-taken-branch mispredicts (replay of the saved sequential
//  instruction). Sequences multi-cycle mult/div ops in EX. Drives the ID_EX
//  segment register's Load_use (bubble) and signal (replay) inputs, plus the
//  PC and IF_ID hold/flush controls. Keeps saturating hazard event counters.
// PARAMETERS
//  MD_LAT   32  EX cycles a mult/div occupies (>=2)
//  CNT_W    16  width of each hazard event counter
// PORTS
//  clk           in   1      pipeline clock; all state updates on negedge clk, same edge as segment registers
//  rst_n         in   1      synchronous, active-low reset, sampled on negedge clk
//  ID_rs         in   5      source register rs of the instruction in ID
//  ID_rt         in   5      source register rt of the instruction in ID
//  ID_use_rt     in   1      ID instruction reads rt (R-type, store, branch)
//  ID_hilo_use   in   1      ID instruction is mfhi/mflo or a mult/div
//  EX_rt         in   5      destination rt of the instruction in EX
//  EX_MemtoReg   in   1      EX instruction is a load
//  EX_RegWr      in   1      EX instruction writes the register file
//  EX_md         in   1      EX instruction is mult/multu/div/divu
//  EX_Branch     in   1      EX instruction is a conditional branch
//  br_taken      in   1      EX branch condition true
//  Load_use      out  1      insert bubble into ID_EX (clear all EX fields)
//  signal        out  1      ID_EX loads the replayed pre_instruction
//  pc_stall      out  1      hold PC
//  if_id_stall   out  1      hold IF_ID
//  if_id_flush   out  1      clear IF_ID (wrong-path fetch)
//  md_busy       out  1      mult/div unit active
//  md_done       out  1      one-cycle pulse: hi/lo valid
//  lu_cnt        out  CNT_W  load-use stall count
//  mp_cnt        out  CNT_W  mispredict count
//  md_cnt        out  CNT_W  mult/div stall-cycle count
// BEHAVIOUR
//  FSM states: RUN, MD_BUSY, MD_DONE. Down-counter cnt, $clog2(MD_LAT) bits.
//  Reset (rst_n=0 at negedge): state=RUN, cnt=0, lu_cnt=mp_cnt=md_cnt=0,
//   md_done=0. All combinational outputs are 0 while in RUN with no hazard.
//  lu_hit = EX_MemtoReg & EX_RegWr & (EX_rt!=0) &
//           (EX_rt==ID_rs | (ID_use_rt & EX_rt==ID_rt)).
//  mispredict = EX_Branch & ~br_taken.
//  Output priority, all combinational from current state and inputs:
//   1. mispredict: signal=1, if_id_flush=1, Load_use=0, no stalls.
//   2. state MD_BUSY & ID_hilo_use: Load_use=1, pc_stall=1, if_id_stall=1.
//   3. lu_hit: Load_use=1, pc_stall=1, if_id_stall=1. Exactly 1 bubble,
//      because the next cycle EX holds the bubble and lu_hit clears.
//   md_busy = (state==MD_BUSY). md_done = (state==MD_DONE).
//  Transitions (negedge clk):
//   RUN     -> MD_BUSY when EX_md & ~mispredict; cnt <= MD_LAT-2.
//   MD_BUSY -> MD_DONE when cnt==0; otherwise cnt <= cnt-1.
//   MD_DONE -> RUN unconditionally (one cycle). A new EX_md in MD_DONE
//              re-enters MD_BUSY directly.
//  An EX_md seen while in MD_BUSY is impossible: ID_hilo_use stalls it.
//  Total mult/div occupancy is MD_LAT cycles including MD_DONE. An ID
//   instruction with ID_hilo_use=0 keeps flowing during MD_BUSY.
//  Counters increment once per cycle their event output is high and
//   saturate at all-ones. lu_cnt counts cause 3, mp_cnt counts cause 1,
//   md_cnt counts cause 2. Only the winning cause counts.
//  Reset mid-mult/div: state returns to RUN, and the partial hi/lo is
//   discarded. This is the owner datapath's concern; no md_done is issued.
// TESTING
//  T1 lw $1 in EX, add $2,$1,$3 in ID -> Load_use=pc_stall=if_id_stall=1
//     for 1 cycle, lu_cnt 0->1, then 0.
//  T2 lw $0 in EX, ID reads $0 -> no stall. Load rt=$5, ID sw reads
//     rt=$5 with ID_use_rt=1 -> stall 1 cycle.
//  T3 beq in EX with br_taken=0 and lu_hit=1 -> signal=1, if_id_flush=1,
//     Load_use=0, mp_cnt+1, lu_cnt unchanged.
//  T4 MD_LAT=4: mult in EX, then mfhi in ID -> md_busy for 3 cycles with
//     Load_use stall, md_done pulse on cycle 4, mfhi advances in cycle 4.
//     md_cnt=3.
//  T5 mult followed by independent addu -> addu is not stalled. Assert
//     rst_n=0 during MD_BUSY -> next cycle state RUN, md_busy=0, no md_done,
//     counters 0.
//  T6 CNT_W=2: force 5 load-use events -> lu_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_use_rt;
    logic             ID_hilo_use;
    logic [4:0]       EX_rt;
    logic             EX_MemtoReg;
    logic             EX_RegWr;
    logic             EX_md;
    logic             EX_Branch;
    logic             br_taken;

    logic             Load_use;
    logic             signal;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic [CNT_W-1:0] md_cnt;

    modport master (
        output ID_rs, ID_rt, ID_use_rt, ID_hilo_use,
        output EX_rt, EX_MemtoReg, EX_RegWr, EX_md, EX_Branch, br_taken,
        input  Load_use, signal, pc_stall, if_id_stall, if_id_flush,
        input  md_busy, md_done, lu_cnt, mp_cnt, md_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rt, ID_hilo_use,
        input  EX_rt, EX_MemtoReg, EX_RegWr, EX_md, EX_Branch, br_taken,
        output Load_use, signal, pc_stall, if_id_stall, if_id_flush,
        output md_busy, md_done, lu_cnt, mp_cnt, md_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, not-taken
// branch replay, mult/div occupancy tracking and saturating hazard counters.
module pipeline_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

    localparam int            CW      = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 2);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, mp_cnt_q, md_cnt_q;

    logic lu_hit, mispredict;
    logic load_use, replay, pc_stall, if_id_stall, if_id_flush;
    logic lu_event, mp_event, md_event;

    assign lu_hit = hz.EX_MemtoReg && hz.EX_RegWr && (hz.EX_rt != 5'd0) &&
                    ((hz.EX_rt == hz.ID_rs) ||
                     (hz.ID_use_rt && (hz.EX_rt == hz.ID_rt)));
    assign mispredict = hz.EX_Branch && !hz.br_taken;

    // Mispredict outranks everything: the ID instruction is wrong-path anyway.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        load_use    = 1'b0;
        replay      = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        lu_event    = 1'b0;
        mp_event    = 1'b0;
        md_event    = 1'b0;
        if (mispredict) begin
            replay      = 1'b1;
            if_id_flush = 1'b1;
            mp_event    = 1'b1;
        end else if ((state_q == MD_BUSY) && hz.ID_hilo_use) begin
            load_use    = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            md_event    = 1'b1;
        end else if (lu_hit) begin
            load_use    = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            lu_event    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN, MD_DONE: begin
                // A mult/div arriving in the done cycle chains straight back in.
                if (hz.EX_md && !mispredict) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_INIT;
                end else begin
                    state_d = RUN;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = RUN;
        endcase
    end

    // Updates share the falling edge with the pipeline segment registers.
    always_ff @(negedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            lu_cnt_q <= '0;
            mp_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lu_event && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (mp_event && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
            if (md_event && (md_cnt_q != '1)) md_cnt_q <= md_cnt_q + CNT_W'(1);
        end
    end

    assign hz.Load_use    = load_use;
    assign hz.signal      = replay;
    assign hz.pc_stall    = pc_stall;
    assign hz.if_id_stall = if_id_stall;
    assign hz.if_id_flush = if_id_flush;
    assign hz.md_busy     = (state_q == MD_BUSY);
    assign hz.md_done     = (state_q == MD_DONE);
    assign hz.lu_cnt      = lu_cnt_q;
    assign hz.mp_cnt      = mp_cnt_q;
    assign hz.md_cnt      = md_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// expected outputs, a monitor compares them mid-cycle.
module tb_pipeline_hazard_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 2;

    // flag order: {Load_use, signal, pc_stall, if_id_stall, if_id_flush, md_busy, md_done}
    localparam logic [6:0] F_NONE   = 7'b0000000;
    localparam logic [6:0] F_STALL  = 7'b1011000;
    localparam logic [6:0] F_MP     = 7'b0100100;
    localparam logic [6:0] F_BUSY   = 7'b0000010;
    localparam logic [6:0] F_BSTALL = 7'b1011010;
    localparam logic [6:0] F_DONE   = 7'b0000001;

    typedef struct packed {
        logic [6:0]       flags;
        logic [CNT_W-1:0] lu;
        logic [CNT_W-1:0] mp;
        logic [CNT_W-1:0] md;
    } obs_t;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_in(input int rs, input int rt, input int use_rt, input int hilo,
                          input int ex_rt, input int mem, input int regwr, input int md,
                          input int br, input int taken);
        hz.ID_rs       = 5'(rs);
        hz.ID_rt       = 5'(rt);
        hz.ID_use_rt   = 1'(use_rt);
        hz.ID_hilo_use = 1'(hilo);
        hz.EX_rt       = 5'(ex_rt);
        hz.EX_MemtoReg = 1'(mem);
        hz.EX_RegWr    = 1'(regwr);
        hz.EX_md       = 1'(md);
        hz.EX_Branch   = 1'(br);
        hz.br_taken    = 1'(taken);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Push the expectation for the cycle whose inputs are already driven, then
    // advance to just after the next falling edge.
    task automatic expect_cycle(input string name, input logic [6:0] flags,
                                input int lu, input int mp, input int md);
        obs_t e;
        e.flags = flags;
        e.lu    = CNT_W'(lu);
        e.mp    = CNT_W'(mp);
        e.md    = CNT_W'(md);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        obs_t  act;
        obs_t  want;
        string n;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                act = {hz.Load_use, hz.signal, hz.pc_stall, hz.if_id_stall, hz.if_id_flush,
                       hz.md_busy, hz.md_done, hz.lu_cnt, hz.mp_cnt, hz.md_cnt};
                want = exp_q.pop_front();
                n    = name_q.pop_front();
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL %s: got flags=%b lu=%0d mp=%0d md=%0d, expected flags=%b lu=%0d mp=%0d md=%0d",
                             n, act.flags, act.lu, act.mp, act.md,
                             want.flags, want.lu, want.mp, want.md);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        expect_cycle("reset", F_NONE, 0, 0, 0);
        rst_n = 1'b1;

        // load-use on rs, then the bubble clears it
        set_in(1, 3, 1, 0, 1, 1, 1, 0, 0, 0); expect_cycle("t1_hit",     F_STALL, 0, 0, 0);
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); expect_cycle("t1_bubble",  F_NONE,  1, 0, 0);
        // $0 never hazards; rt hazard only when ID reads rt; non-writing load ignored
        set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0); expect_cycle("t2_r0",      F_NONE,  1, 0, 0);
        set_in(2, 5, 1, 0, 5, 1, 1, 0, 0, 0); expect_cycle("t2_rt_hit",  F_STALL, 1, 0, 0);
        set_in(2, 5, 1, 0, 0, 0, 0, 0, 0, 0); expect_cycle("t2_bubble",  F_NONE,  2, 0, 0);
        set_in(2, 5, 0, 0, 5, 1, 1, 0, 0, 0); expect_cycle("t2_no_rt",   F_NONE,  2, 0, 0);
        set_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); expect_cycle("t2_no_wr",   F_NONE,  2, 0, 0);
        // mispredict beats a simultaneous load-use
        set_in(4, 0, 0, 0, 4, 1, 1, 0, 1, 0); expect_cycle("t3_mp",      F_MP,    2, 0, 0);
        idle();                                expect_cycle("t3_after",   F_NONE,  2, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); expect_cycle("t3_taken",   F_NONE,  2, 1, 0);
        // mult/div squashed by a mispredict must not start the unit
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); expect_cycle("t3_md_mp",   F_MP,    2, 1, 0);
        idle();                                expect_cycle("t3_no_md",   F_NONE,  2, 2, 0);

        // mult then mfhi: three stalled busy cycles, done pulse lets mfhi go
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_cycle("t4_mult",    F_NONE,  2, 2, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_cycle("t4_busy1",   F_BSTALL, 2, 2, 0);
        expect_cycle("t4_busy2", F_BSTALL, 2, 2, 1);
        expect_cycle("t4_busy3", F_BSTALL, 2, 2, 2);
        expect_cycle("t4_done",  F_DONE,   2, 2, 3);
        idle();                                expect_cycle("t4_after",   F_NONE,  2, 2, 3);

        // independent instruction flows during busy; md_cnt saturated; reset mid-op
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_cycle("t5_mult",    F_NONE,  2, 2, 3);
        set_in(6, 7, 1, 0, 0, 0, 0, 0, 0, 0); expect_cycle("t5_addu",    F_BUSY,  2, 2, 3);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_cycle("t5_md_sat",  F_BSTALL, 2, 2, 3);
        idle();
        rst_n = 1'b0;                          expect_cycle("t5_rst",     F_BUSY,  2, 2, 3);
        rst_n = 1'b1;                          expect_cycle("t5_post",    F_NONE,  0, 0, 0);

        // five load-use events on a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            set_in(3, 0, 0, 0, 3, 1, 1, 0, 0, 0);
            expect_cycle($sformatf("t6_hit%0d", k), F_STALL, (k < 3) ? k : 3, 0, 0);
            set_in(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_cycle($sformatf("t6_bub%0d", k), F_NONE, (k + 1 < 3) ? k + 1 : 3, 0, 0);
        end
        idle();                                expect_cycle("t6_hold",    F_NONE,  3, 0, 0);

        // back-to-back mult/div re-enters busy straight from the done cycle
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_cycle("t7_mult",    F_NONE,  3, 0, 0);
        idle();
        for (int k = 0; k < 3; k++) expect_cycle($sformatf("t7_busy%0d", k), F_BUSY, 3, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_cycle("t7_done_md", F_DONE,  3, 0, 0);
        idle();
        for (int k = 0; k < 3; k++) expect_cycle($sformatf("t7_rebusy%0d", k), F_BUSY, 3, 0, 0);
        expect_cycle("t7_done2", F_DONE, 3, 0, 0);
        expect_cycle("t7_run",   F_NONE, 3, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
